// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, port indices, default widths.
package dmem_pkg;

  localparam int unsigned DEFAULT_ADDR_W = 12;
  localparam int unsigned DEFAULT_DATA_W = 32;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin selector; mask restricts which ports may win.
module rr_pick2
  import dmem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic [1:0] mask,
  output logic [1:0] gnt_c
);

  logic [1:0] elig;

  always_comb begin
    elig  = req & mask;
    gnt_c = 2'b00;
    // contended: the port that did not win last time goes first
    if (elig == 2'b11) begin
      gnt_c = (last == PORT_AUX) ? 2'b01 : 2'b10;
    end else begin
      gnt_c = elig;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter with burst locking that shares the single-port dmem between
// the CPU load/store port (port 0) and an auxiliary requester (port 1).
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEFAULT_ADDR_W,
  parameter int unsigned DATA_W   = DEFAULT_DATA_W,
  parameter int unsigned LOCK_MAX = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic              p0_lock,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic              p1_lock,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p0_gnt,
  output logic              p1_gnt,
  output logic              p0_rvalid,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wren,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);

  arb_state_e       state_q, state_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rd_vld_q, rd_tag_q;
  logic [1:0]       mask, pick, gnt;
  logic             gnt_any, sel, sel_lock;

  // only the owner is eligible while the bus is locked
  always_comb begin
    mask = 2'b11;
    unique case (state_q)
      ST_OWN0: mask = 2'b01;
      ST_OWN1: mask = 2'b10;
      default: mask = 2'b11;
    endcase
  end

  rr_pick2 u_pick (
    .req   ({p1_req, p0_req}),
    .last  (last_q),
    .mask  (mask),
    .gnt_c (pick)
  );

  assign gnt      = reset ? pick : 2'b00;
  assign gnt_any  = |gnt;
  assign sel      = gnt[1];
  assign sel_lock = sel ? p1_lock : p0_lock;

  assign p0_gnt    = gnt[0];
  assign p1_gnt    = gnt[1];
  assign mem_addr  = reset ? (sel ? p1_addr : p0_addr) : '0;
  assign mem_wdata = reset ? (sel ? p1_wdata : p0_wdata) : '0;
  assign mem_wren  = (gnt[0] & p0_we) | (gnt[1] & p1_we);
  assign rdata     = mem_rdata;
  assign p0_rvalid = rd_vld_q & (rd_tag_q == PORT_CPU);
  assign p1_rvalid = rd_vld_q & (rd_tag_q == PORT_AUX);

  // next-state: ownership entry, burst counting and forced release at LOCK_MAX
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    if (gnt_any) begin
      last_d = sel;
    end
    unique case (state_q)
      ST_IDLE: begin
        if (gnt_any && sel_lock && (LOCK_MAX > 1)) begin
          state_d = sel ? ST_OWN1 : ST_OWN0;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_OWN0, ST_OWN1: begin
        if (!gnt_any || !sel_lock || ((32'(cnt_q) + 32'd1) >= LOCK_MAX)) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      last_q   <= PORT_AUX;
      cnt_q    <= '0;
      rd_vld_q <= 1'b0;
      rd_tag_q <= PORT_CPU;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      rd_vld_q <= gnt_any & ~(sel ? p1_we : p0_we);
      rd_tag_q <= sel;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized and directed check of dmem_arbiter against a grant/ownership reference model.
`timescale 1ns/1ps
module tb_dmem_arbiter;

  localparam int unsigned ADDR_W   = 12;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned LOCK_MAX = 16;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [1:0]        req, we, lock;
  logic [ADDR_W-1:0] addr  [2];
  logic [DATA_W-1:0] wdata [2];
  logic              p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, mem_wren;
  logic [DATA_W-1:0] rdata, mem_wdata, mem_rdata;
  logic [ADDR_W-1:0] mem_addr;

  logic [DATA_W-1:0] mem    [4096];
  logic [DATA_W-1:0] shadow [4096];

  int total = 0;
  int bad   = 0;

  // reference model: current owner (-1 none), locked grants so far, last winner
  int                owner, run, lastp, gsel;
  logic [1:0]        exp_rv;
  logic [DATA_W-1:0] exp_rd;
  logic              obs_rv0, obs_rv1, obs_wren;
  logic [DATA_W-1:0] obs_rdata;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOCK_MAX(LOCK_MAX)) dut (
    .clock     (clock),
    .reset     (reset),
    .p0_req    (req[0]),
    .p0_we     (we[0]),
    .p0_lock   (lock[0]),
    .p0_addr   (addr[0]),
    .p0_wdata  (wdata[0]),
    .p1_req    (req[1]),
    .p1_we     (we[1]),
    .p1_lock   (lock[1]),
    .p1_addr   (addr[1]),
    .p1_wdata  (wdata[1]),
    .p0_gnt    (p0_gnt),
    .p1_gnt    (p1_gnt),
    .p0_rvalid (p0_rvalid),
    .p1_rvalid (p1_rvalid),
    .rdata     (rdata),
    .mem_addr  (mem_addr),
    .mem_wren  (mem_wren),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clock = ~clock;

  // write-first single-port dmem with one-cycle read latency
  always @(posedge clock) begin
    if (mem_wren) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem_wren ? mem_wdata : mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int predict();
    if (owner >= 0) return req[owner] ? owner : -1;
    if (req == 2'b11) return (lastp == 1) ? 0 : 1;
    if (req[0]) return 0;
    if (req[1]) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    owner  = -1;
    run    = 0;
    lastp  = 1;
    exp_rv = 2'b00;
  endtask

  task automatic set_port(input int p, input logic r, input logic w, input logic l,
                          input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    req[p]   = r;
    we[p]    = w;
    lock[p]  = l;
    addr[p]  = a;
    wdata[p] = d;
  endtask

  // called just after a falling edge with inputs set; returns at the next falling edge
  task automatic cycle();
    int g;
    #1;
    g         = predict();
    gsel      = g;
    obs_rv0   = p0_rvalid;
    obs_rv1   = p1_rvalid;
    obs_wren  = mem_wren;
    obs_rdata = rdata;
    chk("gnt0", p0_gnt, g == 0);
    chk("gnt1", p1_gnt, g == 1);
    chk("wren", mem_wren, (g >= 0) ? we[g] : 1'b0);
    if (g >= 0) begin
      chk("maddr", mem_addr, addr[g]);
      if (we[g]) chk("mwdata", mem_wdata, wdata[g]);
    end
    chk("rv0", p0_rvalid, exp_rv[0]);
    chk("rv1", p1_rvalid, exp_rv[1]);
    if (exp_rv != 2'b00) chk("rdata", rdata, exp_rd);
    @(posedge clock);
    exp_rv = 2'b00;
    if (g >= 0) begin
      if (we[g]) shadow[addr[g]] = wdata[g];
      else begin
        exp_rv[g] = 1'b1;
        exp_rd    = shadow[addr[g]];
      end
      if (owner < 0) begin
        if (lock[g] && LOCK_MAX > 1) begin
          owner = g;
          run   = 1;
        end
      end else if (!lock[g]) begin
        owner = -1;
      end else begin
        run++;
        if (run >= LOCK_MAX) owner = -1;
      end
      lastp = g;
    end else begin
      owner = -1;
    end
    @(negedge clock);
  endtask

  task automatic reset_dut();
    @(negedge clock);
    reset = 1'b0;
    set_port(0, 1'b1, 1'b1, 1'b1, 12'h123, 32'h1111_1111);
    set_port(1, 1'b1, 1'b1, 1'b1, 12'h456, 32'h2222_2222);
    #1;
    chk("rst_gnt", {p1_gnt, p0_gnt}, 2'b00);
    chk("rst_wren", mem_wren, 1'b0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_rvalid", {p1_rvalid, p0_rvalid}, 2'b00);
    chk("rst_rdata", rdata, mem_rdata);
    @(posedge clock);
    @(negedge clock);
    req   = 2'b00;
    we    = 2'b00;
    lock  = 2'b00;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic new_req(input int p);
    set_port(p, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             ADDR_W'($urandom_range(0, 15)), $urandom);
  endtask

  initial begin
    int k0, k1, b, n0;
    req  = 2'b00;
    we   = 2'b00;
    lock = 2'b00;
    for (int i = 0; i < 2; i++) begin
      addr[i]  = '0;
      wdata[i] = '0;
    end
    for (int i = 0; i < 4096; i++) begin
      mem[i]    = $urandom;
      shadow[i] = mem[i];
    end
    mem[5]    = 32'hDEAD_BEEF;
    shadow[5] = 32'hDEAD_BEEF;
    model_reset();

    // single read with one-cycle return
    reset_dut();
    set_port(0, 1'b1, 1'b0, 1'b0, 12'd5, 32'd0);
    cycle();
    chk("t1_gnt", gsel, 0);
    req[0] = 1'b0;
    cycle();
    chk("t1_rv0", obs_rv0, 1'b1);
    chk("t1_rv1", obs_rv1, 1'b0);
    chk("t1_rdata", obs_rdata, 32'hDEAD_BEEF);

    // both ports writing continuously alternate
    reset_dut();
    k0 = 0;
    k1 = 0;
    set_port(0, 1'b1, 1'b1, 1'b0, 12'd16, 32'h1000_0000);
    set_port(1, 1'b1, 1'b1, 1'b0, 12'd32, 32'h2000_0000);
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("t2_order", gsel, i % 2);
      chk("t2_wren", obs_wren, 1'b1);
      if (gsel == 0) begin
        k0++;
        addr[0]  = ADDR_W'(16 + k0);
        wdata[0] = 32'h1000_0000 | 32'(k0);
      end else if (gsel == 1) begin
        k1++;
        addr[1]  = ADDR_W'(32 + k1);
        wdata[1] = 32'h2000_0000 | 32'(k1);
      end
    end
    req = 2'b00;
    for (int i = 0; i < 3; i++) begin
      chk("t2_mem0", mem[16 + i], 32'h1000_0000 | 32'(i));
      chk("t2_mem1", mem[32 + i], 32'h2000_0000 | 32'(i));
    end

    // p1 locked burst of four while p0 waits
    reset_dut();
    set_port(0, 1'b1, 1'b1, 1'b0, 12'd40, 32'hAAAA_0000);
    cycle();
    chk("t3_pre", gsel, 0);
    set_port(1, 1'b1, 1'b1, 1'b1, 12'd50, 32'hBBBB_0000);
    b = 0;
    for (int j = 0; j < 5; j++) begin
      cycle();
      chk("t3_burst", gsel, (j < 4) ? 1 : 0);
      if (gsel == 1) begin
        b++;
        addr[1]  = ADDR_W'(50 + b);
        wdata[1] = 32'hBBBB_0000 | 32'(b);
        lock[1]  = (b < 3);
        if (b == 4) req[1] = 1'b0;
      end
    end
    req = 2'b00;

    // lock held past LOCK_MAX is broken, p1 gets in, p0 resumes
    reset_dut();
    set_port(0, 1'b1, 1'b1, 1'b1, 12'd60, 32'hC000_0000);
    set_port(1, 1'b1, 1'b1, 1'b0, 12'd70, 32'hD000_0000);
    n0 = 0;
    for (int c = 0; c < 18; c++) begin
      cycle();
      chk("t4_seq", gsel, (c == 16) ? 1 : 0);
      if (gsel == 0) begin
        n0++;
        if (n0 >= 20) req[0] = 1'b0;
        else begin
          addr[0]  = ADDR_W'(60 + n0);
          wdata[0] = 32'hC000_0000 | 32'(n0);
        end
      end else if (gsel == 1) begin
        req[1] = 1'b0;
      end
    end
    req = 2'b00;

    // reset pulse drops an in-flight read
    reset_dut();
    set_port(0, 1'b1, 1'b0, 1'b0, 12'd5, 32'd0);
    #1;
    chk("t5_gnt", p0_gnt, 1'b1);
    #3;
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk("t5_rv", p0_rvalid, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    set_port(1, 1'b1, 1'b0, 1'b0, 12'd6, 32'd0);
    cycle();
    chk("t5_win", gsel, 0);
    req = 2'b00;
    cycle();

    // owner dropping req releases with one idle cycle
    reset_dut();
    set_port(1, 1'b1, 1'b0, 1'b1, 12'd80, 32'd0);
    cycle();
    chk("t6_own", gsel, 1);
    req[1] = 1'b0;
    set_port(0, 1'b1, 1'b0, 1'b0, 12'd81, 32'd0);
    cycle();
    chk("t6_idle", gsel, -1);
    cycle();
    chk("t6_p0", gsel, 0);
    req = 2'b00;
    cycle();

    // random traffic against the reference model
    reset_dut();
    for (int n = 0; n < 3000; n++) begin
      for (int p = 0; p < 2; p++) begin
        if (!req[p] && $urandom_range(0, 2) != 0) new_req(p);
      end
      cycle();
      if (gsel >= 0) req[gsel] = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
